// File: rtl/sdram_sample_port.sv
// Sample-client responder: turns 16-bit sample reads/writes into
// 32-bit Avalon-MM cycles on the SDRAM controller s1 port.
module sdram_sample_port #(
  parameter int TIMEOUT        = 255,
  parameter bit LOW_HALF_FIRST = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        port_read,
  input  logic        port_write,
  input  logic [22:0] port_addr,
  input  logic [15:0] port_writedata,
  output logic [15:0] port_readdata,
  output logic        port_read_finished,
  output logic        port_write_finished,
  output logic        port_timeout,
  output logic [22:0] new_sdram_controller_0_s1_address,
  output logic [3:0]  new_sdram_controller_0_s1_byteenable_n,
  output logic        new_sdram_controller_0_s1_chipselect,
  output logic [31:0] new_sdram_controller_0_s1_writedata,
  output logic        new_sdram_controller_0_s1_read_n,
  output logic        new_sdram_controller_0_s1_write_n,
  input  logic [31:0] new_sdram_controller_0_s1_readdata,
  input  logic        new_sdram_controller_0_s1_readdatavalid,
  input  logic        new_sdram_controller_0_s1_waitrequest
);

  typedef enum logic [2:0] {
    IDLE,
    WR_CMD,
    DONE_W,
    RD_CMD,
    RD_WAIT,
    DONE_R
  } state_e;

  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [22:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic        h_q, h_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        to_q, to_d;

  logic wait_rq;
  logic rdv;
  logic h_in;
  logic accept;
  logic cnt_last;

  assign wait_rq  = new_sdram_controller_0_s1_waitrequest;
  assign rdv      = new_sdram_controller_0_s1_readdatavalid;
  assign h_in     = port_addr[0] ^ ~LOW_HALF_FIRST;
  assign accept   = (state_q == IDLE) && (port_write || port_read);
  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Write has priority; a concurrent read waits for the next IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (port_write) begin
          state_d = WR_CMD;
        end else if (port_read) begin
          state_d = RD_CMD;
        end
      end
      WR_CMD: begin
        if (!wait_rq) begin
          state_d = DONE_W;
        end
      end
      DONE_W: state_d = IDLE;
      RD_CMD: begin
        if (!wait_rq) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (rdv || cnt_last) begin
          state_d = DONE_R;
        end
      end
      DONE_R: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    new_sdram_controller_0_s1_chipselect =
      (state_q == WR_CMD) || (state_q == RD_CMD);
    new_sdram_controller_0_s1_write_n = (state_q != WR_CMD);
    new_sdram_controller_0_s1_read_n  = (state_q != RD_CMD);
    port_write_finished = (state_q == DONE_W);
    port_read_finished  = (state_q == DONE_R);
    port_timeout        = (state_q == DONE_R) && to_q;
  end

  // Request fields are captured once so the client may move on.
  always_comb begin
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    h_d     = h_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    to_d    = 1'b0;
    if (accept) begin
      addr_d = {1'b0, port_addr[22:1]};
      h_d    = h_in;
      be_d   = h_in ? 4'b0011 : 4'b1100;
      wd_d   = h_in ? {port_writedata, 16'h0000}
                    : {16'h0000, port_writedata};
    end
    if ((state_q == RD_CMD) && !wait_rq) begin
      cnt_d = 10'd0;
    end
    if (state_q == RD_WAIT) begin
      cnt_d = 10'(cnt_q + 10'd1);
      if (rdv) begin
        rdata_d = h_q ? new_sdram_controller_0_s1_readdata[31:16]
                      : new_sdram_controller_0_s1_readdata[15:0];
      end else if (cnt_last) begin
        rdata_d = 16'h0000;
        to_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q  <= 23'h0;
      be_q    <= 4'hF;
      wd_q    <= 32'h0;
      h_q     <= 1'b0;
      cnt_q   <= 10'd0;
      rdata_q <= 16'h0;
      to_q    <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      h_q     <= h_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      to_q    <= to_d;
    end
  end

  assign new_sdram_controller_0_s1_address      = addr_q;
  assign new_sdram_controller_0_s1_byteenable_n = be_q;
  assign new_sdram_controller_0_s1_writedata    = wd_q;
  assign port_readdata                          = rdata_q;

endmodule

// File: tb/tb_sdram_sample_port.sv
// Bench for sdram_sample_port: per-cycle expectations derived from
// transaction timing arithmetic, checked on every falling edge.
module tb_sdram_sample_port;

  localparam int T = 8;
  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p_rd = 1'b0;
  logic        p_wr = 1'b0;
  logic [22:0] p_addr = '0;
  logic [15:0] p_wd = '0;
  logic [15:0] p_rdata;
  logic        p_rf, p_wf, p_to;
  logic [22:0] s_addr;
  logic [3:0]  s_be;
  logic        s_cs;
  logic [31:0] s_wd;
  logic        s_rd_n, s_wr_n;
  logic [31:0] s_rdata = '0;
  logic        s_rdv = 1'b0;
  logic        s_wait = 1'b0;

  sdram_sample_port #(.TIMEOUT(T), .LOW_HALF_FIRST(1'b1)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .port_read(p_rd),
    .port_write(p_wr),
    .port_addr(p_addr),
    .port_writedata(p_wd),
    .port_readdata(p_rdata),
    .port_read_finished(p_rf),
    .port_write_finished(p_wf),
    .port_timeout(p_to),
    .new_sdram_controller_0_s1_address(s_addr),
    .new_sdram_controller_0_s1_byteenable_n(s_be),
    .new_sdram_controller_0_s1_chipselect(s_cs),
    .new_sdram_controller_0_s1_writedata(s_wd),
    .new_sdram_controller_0_s1_read_n(s_rd_n),
    .new_sdram_controller_0_s1_write_n(s_wr_n),
    .new_sdram_controller_0_s1_readdata(s_rdata),
    .new_sdram_controller_0_s1_readdatavalid(s_rdv),
    .new_sdram_controller_0_s1_waitrequest(s_wait)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 no command, 1 read command, 2 write command
  int          e_kind [N];
  logic [22:0] e_addr [N];
  logic [3:0]  e_be   [N];
  logic [31:0] e_wd   [N];
  bit          e_rf   [N];
  bit          e_wf   [N];
  bit          e_to   [N];
  logic [15:0] e_rd   [N];

  int nvec = 0;
  int nerr = 0;
  bit go = 1'b0;

  logic [22:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wd;
  logic [15:0] cap_rd;
  int cap_rf_cyc, cap_wf_cyc, cap_to_cyc, cap_rdcmd_cyc;
  int rf_cnt = 0, wf_cnt = 0, to_cnt = 0;
  logic prev_rd_n = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (go && cyc < N) begin
      if (!rst_n) begin
        chk("rst_cs", 32'(s_cs), 32'(0));
        chk("rst_rd_n", 32'(s_rd_n), 32'(1));
        chk("rst_wr_n", 32'(s_wr_n), 32'(1));
        chk("rst_addr", 32'(s_addr), 32'(0));
        chk("rst_be", 32'(s_be), 32'hF);
        chk("rst_wd", s_wd, 32'(0));
        chk("rst_rdata", 32'(p_rdata), 32'(0));
        chk("rst_pulses", 32'({p_rf, p_wf, p_to}), 32'(0));
      end else begin
        chk("cs", 32'(s_cs), 32'(e_kind[cyc] != 0));
        chk("read_n", 32'(s_rd_n), 32'(e_kind[cyc] != 1));
        chk("write_n", 32'(s_wr_n), 32'(e_kind[cyc] != 2));
        chk("read_fin", 32'(p_rf), 32'(e_rf[cyc]));
        chk("write_fin", 32'(p_wf), 32'(e_wf[cyc]));
        chk("timeout", 32'(p_to), 32'(e_to[cyc]));
        if (e_kind[cyc] != 0) begin
          chk("addr", 32'(s_addr), 32'(e_addr[cyc]));
          chk("be_n", 32'(s_be), 32'(e_be[cyc]));
        end
        if (e_kind[cyc] == 2) chk("wdata", s_wd, e_wd[cyc]);
        if (e_rf[cyc]) chk("rdata", 32'(p_rdata), 32'(e_rd[cyc]));
      end
      if (s_cs) begin
        cap_addr = s_addr;
        cap_be   = s_be;
        cap_wd   = s_wd;
      end
      if (!s_rd_n && prev_rd_n) cap_rdcmd_cyc = cyc;
      prev_rd_n = s_rd_n;
      if (p_rf) begin
        cap_rd = p_rdata;
        cap_rf_cyc = cyc;
        rf_cnt++;
      end
      if (p_wf) begin
        cap_wf_cyc = cyc;
        wf_cnt++;
      end
      if (p_to) begin
        cap_to_cyc = cyc;
        to_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [22:0] a, input logic [15:0] d,
                          input int w);
    int c;
    c = cyc;
    for (int k = c + 1; k <= c + 1 + w; k++) begin
      e_kind[k] = 2;
      e_addr[k] = {1'b0, a[22:1]};
      e_be[k]   = a[0] ? 4'b0011 : 4'b1100;
      e_wd[k]   = a[0] ? {d, 16'h0} : {16'h0, d};
    end
    e_wf[c + 2 + w] = 1'b1;
    p_wr = 1'b1;
    p_addr = a;
    p_wd = d;
    tick();
    p_wr = 1'b0;
    p_addr = 23'($urandom);
    p_wd = 16'($urandom);
    for (int i = 0; i <= w; i++) begin
      s_wait = (i < w);
      tick();
    end
    s_wait = 1'b0;
    tick();
  endtask

  // d = cycles after command acceptance that data returns; 0 = never
  task automatic do_read(input logic [22:0] a, input int w, input int d,
                         input logic [31:0] val, input bit late);
    int c, acc, fin;
    c = cyc;
    acc = c + 1 + w;
    fin = (d > 0) ? acc + d + 1 : acc + T + 1;
    for (int k = c + 1; k <= acc; k++) begin
      e_kind[k] = 1;
      e_addr[k] = {1'b0, a[22:1]};
      e_be[k]   = a[0] ? 4'b0011 : 4'b1100;
    end
    e_rf[fin] = 1'b1;
    e_to[fin] = (d == 0);
    e_rd[fin] = (d == 0) ? 16'h0 : (a[0] ? val[31:16] : val[15:0]);
    p_rd = 1'b1;
    p_addr = a;
    tick();
    p_rd = 1'b0;
    p_addr = 23'($urandom);
    for (int i = 0; i <= w; i++) begin
      s_wait = (i < w);
      tick();
    end
    s_wait = 1'b0;
    while (cyc <= fin) begin
      s_rdv = (d > 0) && (cyc == acc + d);
      s_rdata = s_rdv ? val : 32'($urandom);
      tick();
    end
    s_rdv = 1'b0;
    if (late) begin
      s_rdv = 1'b1;
      s_rdata = 32'hDEADBEEF;
      tick();
      s_rdv = 1'b0;
    end
  endtask

  task automatic do_both(input logic [22:0] wa, input logic [15:0] wd,
                         input logic [22:0] ra, input int d,
                         input logic [31:0] val);
    int c, acc, fin;
    c = cyc;
    e_kind[c + 1] = 2;
    e_addr[c + 1] = {1'b0, wa[22:1]};
    e_be[c + 1]   = wa[0] ? 4'b0011 : 4'b1100;
    e_wd[c + 1]   = wa[0] ? {wd, 16'h0} : {16'h0, wd};
    e_wf[c + 2]   = 1'b1;
    acc = c + 4;
    fin = acc + d + 1;
    e_kind[acc] = 1;
    e_addr[acc] = {1'b0, ra[22:1]};
    e_be[acc]   = ra[0] ? 4'b0011 : 4'b1100;
    e_rf[fin]   = 1'b1;
    e_rd[fin]   = ra[0] ? val[31:16] : val[15:0];
    p_wr = 1'b1;
    p_rd = 1'b1;
    p_addr = wa;
    p_wd = wd;
    tick();
    p_wr = 1'b0;
    p_addr = ra;
    tick();
    tick();
    tick();
    p_rd = 1'b0;
    while (cyc <= fin) begin
      s_rdv = (cyc == acc + d);
      s_rdata = s_rdv ? val : 32'($urandom);
      tick();
    end
    s_rdv = 1'b0;
  endtask

  int s, rf0;

  initial begin
    for (int k = 0; k < N; k++) begin
      e_kind[k] = 0;
      e_addr[k] = '0;
      e_be[k]   = '0;
      e_wd[k]   = '0;
      e_rf[k]   = 1'b0;
      e_wf[k]   = 1'b0;
      e_to[k]   = 1'b0;
      e_rd[k]   = '0;
    end
    go = 1'b1;
    tick();
    tick();
    chk("init_be", 32'(s_be), 32'h0000000F);
    chk("init_rdn", 32'({s_rd_n, s_wr_n, s_cs}), 32'h6);
    rst_n = 1'b1;
    tick();

    s = cyc;
    do_write(23'h000005, 16'hBEEF, 0);
    chk("w1_addr", 32'(cap_addr), 32'h2);
    chk("w1_be", 32'(cap_be), 32'h3);
    chk("w1_wd", cap_wd, 32'hBEEF0000);
    chk("w1_lat", 32'(cap_wf_cyc - s), 32'd2);
    chk("w1_cnt", 32'(wf_cnt), 32'd1);

    s = cyc;
    do_write(23'h000010, 16'hA5A5, 3);
    chk("w2_wd", cap_wd, 32'h0000A5A5);
    chk("w2_lat", 32'(cap_wf_cyc - s), 32'd5);

    s = cyc;
    do_read(23'h000004, 0, 5, 32'h12345678, 1'b0);
    chk("r1_data", 32'(cap_rd), 32'h5678);
    chk("r1_be", 32'(cap_be), 32'hC);
    chk("r1_lat", 32'(cap_rf_cyc - s), 32'd7);

    do_read(23'h000005, 0, 5, 32'h12345678, 1'b0);
    chk("r2_data", 32'(cap_rd), 32'h1234);

    do_read(23'h007FF3, 2, 3, 32'hCAFEF00D, 1'b0);
    do_write(23'h7FFFFE, 16'h0123, 1);

    s = cyc;
    rf0 = rf_cnt;
    do_read(23'h000008, 0, 0, 32'h0, 1'b1);
    chk("to_lat", 32'(cap_to_cyc - s), 32'(T + 2));
    chk("to_data", 32'(cap_rd), 32'h0);
    chk("to_late", 32'(rf_cnt - rf0), 32'd1);

    do_read(23'h000009, 1, T, 32'h55AA33CC, 1'b0);
    chk("edge_data", 32'(cap_rd), 32'h55AA);
    chk("edge_to", 32'(to_cnt), 32'd1);

    do_both(23'h000020, 16'h7777, 23'h000031, 2, 32'h9ABCDEF0);
    chk("both_gap", 32'(cap_rdcmd_cyc - cap_wf_cyc), 32'd2);
    chk("both_data", 32'(cap_rd), 32'h9ABC);

    rf0 = rf_cnt;
    p_rd = 1'b1;
    p_addr = 23'h000040;
    e_kind[cyc + 1] = 1;
    e_addr[cyc + 1] = 23'h20;
    e_be[cyc + 1]   = 4'b1100;
    tick();
    p_rd = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    s_rdv = 1'b1;
    s_rdata = 32'hFEEDFACE;
    tick();
    s_rdv = 1'b0;
    tick();
    chk("rst_nofin", 32'(rf_cnt - rf0), 32'd0);

    do_read(23'h000041, 0, 1, 32'hBEADCAFE, 1'b0);
    chk("post_rst", 32'(cap_rd), 32'hBEAD);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sdram_sample_port.md
Name: sdram_sample_port

Overview:
- Responder end of the 16-bit sample client protocol (read/addr/readdata/read_finished, write/writedata/write_finished) used by the record, play, mix and pitch engines.
- Converts one client's sample accesses into Avalon-MM master cycles on the 32-bit SDRAM controller s1 port.
- Handles address halving, byte-lane selection, waitrequest stalls, pipelined readdatavalid return and a read timeout.
- One instance sits between the SDRAM arbiter grant and the controller.

Parameters:
- TIMEOUT, 255, max cycles from read-command acceptance to readdatavalid before the read is abandoned (1..1023).
- LOW_HALF_FIRST, 1, 1: sample addr[0]=0 maps to bytes 1:0; 0: maps to bytes 3:2.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- port_read  in  1  client read request (level)
- port_write  in  1  client write request (level)
- port_addr  in  23  sample address
- port_writedata  in  16  sample to write
- port_readdata  out  16  returned sample, valid with port_read_finished
- port_read_finished  out  1  one-cycle read-done pulse
- port_write_finished  out  1  one-cycle write-done pulse
- port_timeout  out  1  one-cycle pulse with port_read_finished when a read times out
- new_sdram_controller_0_s1_address  out  23  word address
- new_sdram_controller_0_s1_byteenable_n  out  4  active-low byte enables
- new_sdram_controller_0_s1_chipselect  out  1  chip select
- new_sdram_controller_0_s1_writedata  out  32  write word
- new_sdram_controller_0_s1_read_n  out  1  active-low read
- new_sdram_controller_0_s1_write_n  out  1  active-low write
- new_sdram_controller_0_s1_readdata  in  32  read word
- new_sdram_controller_0_s1_readdatavalid  in  1  read word valid
- new_sdram_controller_0_s1_waitrequest  in  1  controller stall

Behaviour:
- Clocking and reset: single clock domain. Asynchronous active-low reset.
- Reset values: state IDLE; read_n=1, write_n=1, chipselect=0; address=0, writedata=0, byteenable_n=4'hF; port_readdata=0; all finished/timeout pulses 0.
- Reset asserted mid-transaction aborts it: no finished pulse, and a late readdatavalid after reset release is ignored in IDLE.
- Address mapping: word address = {1'b0, port_addr[22:1]}; half select h = port_addr[0] ^ ~LOW_HALF_FIRST.
  - h=0: byteenable_n=4'b1100, writedata={16'h0, data}.
  - h=1: byteenable_n=4'b0011, writedata={data, 16'h0}.
- Address, data, byteenable and h are latched on acceptance in IDLE; the client may change inputs after acceptance.
- IDLE:
  - If port_write=1, go to WR_CMD. Write wins when port_read and port_write are both 1 in the same cycle; the read is serviced on the next acceptance if still asserted.
  - Else if port_read=1, go to RD_CMD.
  - Acceptance takes one cycle; the command drives from the next cycle.
- WR_CMD: chipselect=1, write_n=0. Hold all signals stable while waitrequest=1. On a cycle with waitrequest=0, go to DONE_W, deasserting the command next cycle.
- DONE_W: pulse port_write_finished for 1 cycle, return to IDLE.
- RD_CMD: chipselect=1, read_n=0, held while waitrequest=1. On waitrequest=0, go to RD_WAIT and clear the timeout counter.
- RD_WAIT: command deasserted; counter increments each cycle.
  - readdatavalid=1: port_readdata = h ? readdata[31:16] : readdata[15:0], registered; next cycle pulse port_read_finished; return to IDLE.
  - readdatavalid arrives in the same cycle the counter reaches TIMEOUT: data wins, no timeout.
  - Counter reaches TIMEOUT with no data: port_readdata=0, pulse port_read_finished and port_timeout together, return to IDLE.
  - A readdatavalid arriving after a timeout, while in IDLE or another transaction's RD_CMD, is discarded. At most one read is outstanding.
- Client rule: a request held high past its finished pulse is treated as a new request, re-sampled in IDLE on the cycle after the pulse.
- Minimum latency, zero waitrequest:
  - Write: accept → command 1 cycle → finished. Finished is 2 cycles after the request is first seen.
  - Read: finished is 1 cycle after readdatavalid.
- Throughput: one transaction in flight; back-to-back requests incur one IDLE cycle each.

Test Plan:
- Write addr=0x000005, data=0xBEEF, waitrequest=0: one write cycle with address=0x000002, byteenable_n=4'b0011, writedata=0xBEEF0000; port_write_finished pulses once, 2 cycles after the request.
- Write with waitrequest=1 for 3 cycles: write_n, address and writedata held stable for 4 cycles; finished only after release.
- Read addr=0x000004, readdatavalid 5 cycles later with readdata=0x12345678: byteenable_n=4'b1100; port_readdata=0x5678 with port_read_finished 1 cycle after valid. Repeat at addr=0x000005: returns 0x1234.
- Read with TIMEOUT=8 and no readdatavalid: port_read_finished and port_timeout pulse together 8 cycles after command acceptance, port_readdata=0. A late readdatavalid is then ignored.
- port_read and port_write both high: write issued first; read issued after write_finished plus one IDLE cycle.
- Assert i_rst_n=0 during RD_WAIT: outputs return to reset values immediately; no finished pulse; the next request completes normally.
